axi_burst_rd_mux: RTL
=====================

// Module: axi_burst_rd_mux
// PURPOSE
//  Multi-channel AXI burst read master for the DDR controller's user side.
//  NUM_CH requesters (frame reader, feature fetch, ...) each present a start address and burst length.
//  Requests are arbitrated round-robin, one AR address phase is issued per grant, and every R beat
//  of the burst is streamed out tagged with channel ID and last flag.
//  Successor to the single-beat read controller: variable burst length, per-beat output, rlast checking.
// PARAMETERS
//  DATA_W  256  AXI read data width (`MEM_DQ_WIDTH*8)
//  ADDR_W  28   AXI address width (`CTRL_ADDR_WIDTH)
//  LEN_W   4    burst length field width; value = beats-1
//  NUM_CH  2    number of requesting channels, >=1
//  CH_W    $clog2(NUM_CH) (min 1), localparam
// PORTS
//  clk_100M       in   1             system clock, all logic on rising edge
//  rst            in   1             synchronous reset, active-high
//  init_done      in   1             DDR calibration done; gates new grants only
//  rd_req         in   NUM_CH        level request per channel, held until rd_ack
//  rd_addr        in   NUM_CH*ADDR_W packed start address, ch0 in LSBs
//  rd_len         in   NUM_CH*LEN_W  packed burst length (beats-1)
//  rd_ack         out  NUM_CH        1-cycle pulse: channel's request accepted
//  rd_busy        out  1             high from grant until burst complete
//  rd_data        out  DATA_W        registered beat data
//  rd_data_valid  out  1             1-cycle strobe per beat
//  rd_data_ch     out  CH_W          owning channel of current beat/burst
//  rd_data_last   out  1             with rd_data_valid on final beat
//  rd_err         out  1             with final beat: rlast arrived at beat count != len+1
//  axi_araddr     out  ADDR_W        burst address
//  axi_arlen      out  LEN_W         burst length
//  axi_arvalid    out  1             AR valid
//  axi_arready    in   1             AR ready
//  axi_rready     out  1             high only in DATA state
//  axi_rdata      in   DATA_W        R data
//  axi_rvalid     in   1             R valid
//  axi_rlast      in   1             R last
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, RR pointer = ch0, beat counter 0.
//    Reset mid-burst abandons the transfer; no rd_data_last is issued.
//  - FSM IDLE -> ADDR -> DATA -> IDLE, one-hot.
//  - IDLE: if init_done && |rd_req at edge k, then at edge k:
//    * grant per RR, latch addr/len/ch;
//    * rd_ack[g]=1 for one cycle, rd_busy=1, axi_arvalid=1, state ADDR.
//  - init_done low blocks grants only; an in-flight burst completes.
//  - ADDR: hold arvalid/araddr/arlen stable until arvalid&&arready, then arvalid=0 and enter DATA.
//    No timeout.
//  - DATA: axi_rready=1. Each rvalid beat registers rd_data<=rdata and rd_data_valid=1 one cycle
//    later; beat_cnt increments, wrapping is impossible (LEN_W+1 bits).
//  - Burst ends on rvalid&&rlast only:
//    * rd_data_last=1 on that output beat;
//    * rd_err=1 if beat_cnt != len (count before increment);
//    * rd_busy=0 and state IDLE on the same edge as the last output beat.
//  - Beats beyond len+1 before rlast are still forwarded (error flagged at rlast).
//  - rd_data_ch is valid from grant until next grant.
//  - Min turnaround: new grant possible on the edge after rd_data_last (IDLE sees req).
//  - RR: pointer moves to (granted+1) mod NUM_CH after each grant. Search starts at pointer.
//    Simultaneous requests are served in rotation; no channel starves.
//  - rd_addr/rd_len are sampled only at grant; changes afterwards are ignored.
// STRUCTURE
//  - Shared header p_ddr.v keeps CTRL_ADDR_WIDTH, MEM_DQ_WIDTH used as defaults.
//    FSM encodings are localparams.
//  - Sub-module rr_arbiter #(NUM_CH): inputs req, advance; outputs one-hot grant and grant index.
//    Pointer register lives inside it.
// TESTING
//  1. rst held, then released, init_done=0, rd_req=01 -> no rd_ack, arvalid=0.
//     Set init_done=1 -> rd_ack=01 next edge.
//  2. ch0 addr=0x0000100, len=3, arready after 2 cycles, 4 beats D0..D3, rlast on D3 ->
//     4 strobes, data D0..D3, ch=0, last on D3, rd_err=0, rd_busy drops with last.
//  3. rd_req=11 continuously, len=0 each -> grants alternate ch0,ch1,ch0,ch1.
//     araddr matches each channel's address.
//  4. len=3 but rlast on beat 2 -> burst ends after 2 beats, rd_data_last=1, rd_err=1.
//  5. rvalid gaps (beat every 3rd cycle) and arready held low 10 cycles -> arvalid stays high,
//     addr stable, all beats delivered in order.
//  6. rst asserted during DATA after beat 1 -> next cycle all outputs 0, state IDLE.
//     Fresh request is then served normally.

Source files
------------

// File: rtl/axi_burst_rd_mux_pkg.sv
// Shared definitions for the multi-channel AXI burst read master:
// default widths taken from the DDR controller's user-side geometry,
// one-hot FSM encodings and a channel-index width helper.
package axi_burst_rd_mux_pkg;

    // DDR controller geometry used for default port widths
    localparam int CTRL_ADDR_WIDTH = 28;
    localparam int MEM_DQ_WIDTH    = 32;

    localparam int DEF_DATA_W = MEM_DQ_WIDTH * 8;
    localparam int DEF_ADDR_W = CTRL_ADDR_WIDTH;
    localparam int DEF_LEN_W  = 4;
    localparam int DEF_NUM_CH = 2;

    // One-hot FSM encoding
    typedef logic [2:0] state_t;
    localparam logic [2:0] ST_IDLE = 3'b001;
    localparam logic [2:0] ST_ADDR = 3'b010;
    localparam logic [2:0] ST_DATA = 3'b100;

    // Channel index width, never narrower than one bit
    function automatic int ch_width(input int num_ch);
        if (num_ch > 1) begin
            return $clog2(num_ch);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/axi_burst_rd_mux_rr_arbiter.sv
// Round-robin arbiter: the search for a requester starts at the rotating
// pointer; on an accepted grant the pointer moves just past the winner so
// simultaneous requesters are served in rotation and none starves.
module rr_arbiter
    import axi_burst_rd_mux_pkg::*;
#(
    parameter  int NUM_CH = DEF_NUM_CH,
    localparam int CH_W   = ch_width(NUM_CH)
)(
    input  logic              clk_100M,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              advance,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   grant_idx,
    output logic              grant_valid
);

    logic [CH_W-1:0] ptr_r;
    logic [CH_W-1:0] idx_s;
    logic [CH_W-1:0] cand_idx_s;
    logic            found_s;
    int              cand_s;

    // Find the first requester at or after the pointer (scan backwards so the nearest one wins)
    always_comb begin
        idx_s      = '0;
        found_s    = 1'b0;
        cand_s     = 0;
        cand_idx_s = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            cand_s     = (int'(ptr_r) + i) % NUM_CH;
            cand_idx_s = CH_W'(cand_s);
            if (req[cand_idx_s]) begin
                idx_s   = cand_idx_s;
                found_s = 1'b1;
            end else begin
                idx_s   = idx_s;
                found_s = found_s;
            end
        end
    end

    // One-hot form of the winning index
    always_comb begin
        grant = '0;
        if (found_s) begin
            grant[idx_s] = 1'b1;
        end else begin
            grant = '0;
        end
    end

    assign grant_idx   = idx_s;
    assign grant_valid = found_s;

    // Rotate the pointer to the channel after the one just granted
    always_ff @(posedge clk_100M) begin
        if (rst) begin
            ptr_r <= '0;
        end else if (advance && found_s) begin
            ptr_r <= (idx_s == CH_W'(NUM_CH - 1)) ? '0 : idx_s + 1'b1;
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/axi_burst_rd_mux.sv
// Multi-channel AXI burst read master. Requesters are granted round-robin,
// one AR phase is issued per grant and every R beat is forwarded as a
// registered strobe tagged with channel, last flag and a length-mismatch error.
module axi_burst_rd_mux
    import axi_burst_rd_mux_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int ADDR_W = DEF_ADDR_W,
    parameter  int LEN_W  = DEF_LEN_W,
    parameter  int NUM_CH = DEF_NUM_CH,
    localparam int CH_W   = ch_width(NUM_CH)
)(
    input  logic                     clk_100M,
    input  logic                     rst,
    input  logic                     init_done,
    input  logic [NUM_CH-1:0]        rd_req,
    input  logic [NUM_CH*ADDR_W-1:0] rd_addr,
    input  logic [NUM_CH*LEN_W-1:0]  rd_len,
    output logic [NUM_CH-1:0]        rd_ack,
    output logic                     rd_busy,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_data_valid,
    output logic [CH_W-1:0]          rd_data_ch,
    output logic                     rd_data_last,
    output logic                     rd_err,
    output logic [ADDR_W-1:0]        axi_araddr,
    output logic [LEN_W-1:0]         axi_arlen,
    output logic                     axi_arvalid,
    input  logic                     axi_arready,
    output logic                     axi_rready,
    input  logic [DATA_W-1:0]        axi_rdata,
    input  logic                     axi_rvalid,
    input  logic                     axi_rlast
);

    state_t            state_r;
    logic [LEN_W:0]    beat_cnt_r;
    logic [NUM_CH-1:0] grant_s;
    logic [CH_W-1:0]   grant_idx_s;
    logic              grant_valid_s;
    logic              advance_s;

    // A grant is taken only from IDLE and only once calibration is done
    assign advance_s = (state_r == ST_IDLE) && init_done && grant_valid_s;

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .clk_100M    (clk_100M),
        .rst         (rst),
        .req         (rd_req),
        .advance     (advance_s),
        .grant       (grant_s),
        .grant_idx   (grant_idx_s),
        .grant_valid (grant_valid_s)
    );

    // Burst sequencing: grant/latch in IDLE, AR handshake in ADDR, beat forwarding in DATA
    always_ff @(posedge clk_100M) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            beat_cnt_r    <= '0;
            rd_ack        <= '0;
            rd_busy       <= 1'b0;
            rd_data       <= '0;
            rd_data_valid <= 1'b0;
            rd_data_ch    <= '0;
            rd_data_last  <= 1'b0;
            rd_err        <= 1'b0;
            axi_araddr    <= '0;
            axi_arlen     <= '0;
            axi_arvalid   <= 1'b0;
            axi_rready    <= 1'b0;
        end else begin
            // pulse-type outputs default low every cycle
            rd_ack        <= '0;
            rd_data_valid <= 1'b0;
            rd_data_last  <= 1'b0;
            rd_err        <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (advance_s) begin
                        rd_ack      <= grant_s;
                        rd_busy     <= 1'b1;
                        axi_arvalid <= 1'b1;
                        axi_araddr  <= rd_addr[grant_idx_s*ADDR_W +: ADDR_W];
                        axi_arlen   <= rd_len[grant_idx_s*LEN_W +: LEN_W];
                        rd_data_ch  <= grant_idx_s;
                        beat_cnt_r  <= '0;
                        state_r     <= ST_ADDR;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ADDR: begin
                    if (axi_arvalid && axi_arready) begin
                        axi_arvalid <= 1'b0;
                        axi_rready  <= 1'b1;
                        state_r     <= ST_DATA;
                    end else begin
                        state_r <= ST_ADDR;
                    end
                end
                ST_DATA: begin
                    if (axi_rvalid) begin
                        rd_data       <= axi_rdata;
                        rd_data_valid <= 1'b1;
                        // saturate so a runaway slave cannot wrap the count back to a match
                        beat_cnt_r    <= (beat_cnt_r == {(LEN_W+1){1'b1}}) ? beat_cnt_r
                                                                         : beat_cnt_r + 1'b1;
                        if (axi_rlast) begin
                            rd_data_last <= 1'b1;
                            rd_err       <= (beat_cnt_r != {1'b0, axi_arlen});
                            rd_busy      <= 1'b0;
                            axi_rready   <= 1'b0;
                            beat_cnt_r   <= '0;
                            state_r      <= ST_IDLE;
                        end else begin
                            state_r <= ST_DATA;
                        end
                    end else begin
                        state_r <= ST_DATA;
                    end
                end
                default: begin
                    // illegal encoding: drop any transfer and return to a safe idle
                    rd_busy     <= 1'b0;
                    axi_arvalid <= 1'b0;
                    axi_rready  <= 1'b0;
                    beat_cnt_r  <= '0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
